// File: rtl/huff_min2_sched.sv
// Two-minimum scheduler for Huffman tree building. It walks the node table
// and finds the smallest and second-smallest active frequencies. Every
// magnitude comparison goes through one shared external comparator, and each
// comparison runs as a clear / start / wait-done transaction.
module huff_min2_sched #(
  parameter int NODES       = 16,
  parameter int IDXW        = 4,
  parameter int DW          = 9,
  parameter int CMP_TIMEOUT = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic [IDXW:0]   node_count_i,
  output logic [IDXW-1:0] rd_addr_o,
  output logic            rd_en_o,
  input  logic [DW-1:0]   rd_data_i,
  input  logic            rd_active_i,
  output logic            cmp_reset_o,
  output logic            cmp_start_o,
  output logic [31:0]     cmp_num_bits_o,
  output logic [DW-1:0]   cmp_a_o,
  output logic [DW-1:0]   cmp_b_o,
  input  logic            cmp_done_i,
  input  logic            cmp_lt_i,
  input  logic            cmp_eq_i,
  input  logic            cmp_gt_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [IDXW-1:0] min1_idx_o,
  output logic [IDXW-1:0] min2_idx_o,
  output logic [DW-1:0]   min1_val_o,
  output logic [DW-1:0]   min2_val_o,
  output logic            too_few_o,
  output logic            timeout_err_o
);

  localparam int WDW = $clog2(CMP_TIMEOUT + 1);
  localparam logic [IDXW:0] ONE = (IDXW+1)'(1);
  localparam logic [IDXW:0] TWO = (IDXW+1)'(2);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_EVAL, S_CLR, S_CMP, S_UPD, S_FIN} state_t;
  // P_FIRST: second active node vs min1; P_MIN2: node vs min2; P_SECOND: follow-up vs min1
  typedef enum logic [1:0] {P_FIRST, P_MIN2, P_SECOND} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [IDXW:0]   cnt_q, cnt_d;
  logic [IDXW:0]   i_q, i_d;
  logic [1:0]      found_q, found_d;   // saturates at 2; only "<2" matters afterwards
  logic [DW-1:0]   node_val_q, node_val_d;
  logic            node_act_q, node_act_d;
  logic            lt_q, lt_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [IDXW-1:0] m1i_q, m1i_d, m2i_q, m2i_d;
  logic [DW-1:0]   m1v_q, m1v_d, m2v_q, m2v_d;
  logic            too_few_q, too_few_d, tmo_q, tmo_d;
  logic            skip;

  // Only the less-than flag decides anything; ties deliberately keep the older node.
  logic unused_flags;
  assign unused_flags = cmp_eq_i ^ cmp_gt_i;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      phase_q    <= P_FIRST;
      cnt_q      <= '0;
      i_q        <= '0;
      found_q    <= '0;
      node_val_q <= '0;
      node_act_q <= 1'b0;
      lt_q       <= 1'b0;
      wd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m1i_q      <= '0;
      m2i_q      <= '0;
      m1v_q      <= '0;
      m2v_q      <= '0;
      too_few_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      i_q        <= i_d;
      found_q    <= found_d;
      node_val_q <= node_val_d;
      node_act_q <= node_act_d;
      lt_q       <= lt_d;
      wd_q       <= wd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m1i_q      <= m1i_d;
      m2i_q      <= m2i_d;
      m1v_q      <= m1v_d;
      m2v_q      <= m2v_d;
      too_few_q  <= too_few_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state and datapath updates for the scan / compare sequence
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    i_d        = i_q;
    found_d    = found_q;
    node_val_d = node_val_q;
    node_act_d = node_act_q;
    lt_d       = lt_q;
    wd_d       = wd_q;
    a_d        = a_q;
    b_d        = b_q;
    m1i_d      = m1i_q;
    m2i_d      = m2i_q;
    m1v_d      = m1v_q;
    m2v_d      = m2v_q;
    too_few_d  = too_few_q;
    tmo_d      = tmo_q;
    skip       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d     = node_count_i;
          i_d       = '0;
          found_d   = '0;
          too_few_d = 1'b0;
          tmo_d     = 1'b0;
          if (node_count_i < TWO) begin
            too_few_d = 1'b1;
            state_d   = S_FIN;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_WT;
      S_WT: begin
        node_val_d = rd_data_i;
        node_act_d = rd_active_i;
        state_d    = S_EVAL;
      end
      S_EVAL: begin
        if (!node_act_q) begin
          skip = 1'b1;
        end else if (found_q == 2'd0) begin
          m1i_d   = i_q[IDXW-1:0];
          m1v_d   = node_val_q;
          found_d = 2'd1;
          skip    = 1'b1;
        end else begin
          phase_d = (found_q == 2'd1) ? P_FIRST : P_MIN2;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        a_d     = node_val_q;
        b_d     = (phase_q == P_MIN2) ? m2v_q : m1v_q;
        wd_d    = '0;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (cmp_done_i) begin
          lt_d    = cmp_lt_i;
          state_d = S_UPD;
        end else if (wd_q == WDW'(CMP_TIMEOUT)) begin
          tmo_d     = 1'b1;
          too_few_d = (found_q < 2'd2);
          state_d   = S_FIN;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_UPD: begin
        if (phase_q == P_MIN2 && lt_q) begin
          // Beat min2; now see whether it also beats min1
          phase_d = P_SECOND;
          state_d = S_CLR;
        end else begin
          if (phase_q != P_MIN2) begin
            if (lt_q) begin
              m2i_d = m1i_q;
              m2v_d = m1v_q;
              m1i_d = i_q[IDXW-1:0];
              m1v_d = node_val_q;
            end else begin
              m2i_d = i_q[IDXW-1:0];
              m2v_d = node_val_q;
            end
          end
          found_d = 2'd2;
          skip    = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (skip) begin
      if (i_q == cnt_q - ONE) begin
        too_few_d = (found_d < 2'd2);
        state_d   = S_FIN;
      end else begin
        i_d     = i_q + ONE;
        state_d = S_RD;
      end
    end
  end

  assign rd_en_o        = (state_q == S_RD);
  assign rd_addr_o      = (state_q == S_RD) ? i_q[IDXW-1:0] : '0;
  assign cmp_reset_o    = (state_q == S_IDLE) || (state_q == S_FIN) || (state_q == S_CLR);
  assign cmp_start_o    = (state_q == S_CMP);
  assign cmp_num_bits_o = 32'(DW);
  assign cmp_a_o        = a_q;
  assign cmp_b_o        = b_q;
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done_o         = (state_q == S_FIN);
  assign min1_idx_o     = m1i_q;
  assign min2_idx_o     = m2i_q;
  assign min1_val_o     = m1v_q;
  assign min2_val_o     = m2v_q;
  assign too_few_o      = too_few_q;
  assign timeout_err_o  = tmo_q;

endmodule

// File: tb/tb_huff_min2_sched.sv
// Bench for huff_min2_sched: node table and comparator models, a reference
// that picks the two smallest active entries by plain search, and one
// per-cycle checker.
module tb_huff_min2_sched;
  localparam int IDXW = 4;
  localparam int DW   = 9;
  localparam int TMO  = 32;

  logic clk = 0, reset_ni = 0, start_i = 0;
  logic [IDXW:0] node_count_i = '0;
  logic [IDXW-1:0] rd_addr_o, min1_idx_o, min2_idx_o;
  logic rd_en_o, cmp_reset_o, cmp_start_o, busy_o, done_o, too_few_o, timeout_err_o;
  logic [31:0] cmp_num_bits_o;
  logic [DW-1:0] cmp_a_o, cmp_b_o, min1_val_o, min2_val_o;
  logic [DW-1:0] rd_data_i = '0;
  logic rd_active_i = 0;
  logic c_done = 0, c_lt = 0, c_eq = 0, c_gt = 0;

  huff_min2_sched dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .node_count_i(node_count_i),
    .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o), .rd_data_i(rd_data_i), .rd_active_i(rd_active_i),
    .cmp_reset_o(cmp_reset_o), .cmp_start_o(cmp_start_o), .cmp_num_bits_o(cmp_num_bits_o),
    .cmp_a_o(cmp_a_o), .cmp_b_o(cmp_b_o), .cmp_done_i(c_done), .cmp_lt_i(c_lt),
    .cmp_eq_i(c_eq), .cmp_gt_i(c_gt), .busy_o(busy_o), .done_o(done_o),
    .min1_idx_o(min1_idx_o), .min2_idx_o(min2_idx_o), .min1_val_o(min1_val_o),
    .min2_val_o(min2_val_o), .too_few_o(too_few_o), .timeout_err_o(timeout_err_o));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, cmp_enter_cyc = 0, done_cyc = 0;
  int cmp_lat = 3, c_cnt = 0;
  bit hang = 0;
  int tb_freq [16];
  bit tb_act  [16];
  int exp_m1i, exp_m2i, exp_m1v, exp_m2v;
  bit exp_tf, exp_to;
  logic prev_start = 0;
  logic [DW-1:0] prev_a = '0, prev_b = '0;

  task automatic check(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Node table: registered read, data valid the cycle after rd_en
  always @(posedge clk) if (rd_en_o) begin
    rd_data_i   <= DW'(tb_freq[rd_addr_o]);
    rd_active_i <= tb_act[rd_addr_o];
  end

  // Comparator: sticky flags, cleared by cmp_reset, result cmp_lat cycles into start
  always @(posedge clk) begin
    if (cmp_reset_o) begin
      c_done <= 0; c_lt <= 0; c_eq <= 0; c_gt <= 0; c_cnt <= 0;
    end else if (cmp_start_o && !c_done && !hang) begin
      if (c_cnt == cmp_lat - 1) begin
        c_done <= 1;
        c_lt <= (cmp_a_o < cmp_b_o);
        c_eq <= (cmp_a_o == cmp_b_o);
        c_gt <= (cmp_a_o > cmp_b_o);
      end else c_cnt <= c_cnt + 1;
    end
  end

  // Per-cycle checker
  always @(negedge clk) begin
    if (reset_ni) begin
      check("num_bits", cmp_num_bits_o, DW);
      check("start_reset_excl", cmp_start_o & cmp_reset_o, 0);
      if (cmp_start_o && prev_start) begin
        check("cmp_a_stable", cmp_a_o, prev_a);
        check("cmp_b_stable", cmp_b_o, prev_b);
      end
      if (cmp_start_o && !prev_start) cmp_enter_cyc <= cyc;
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        check("busy_at_done", busy_o, 0);
        check("timeout_err", timeout_err_o, exp_to);
        if (!exp_to) check("too_few", too_few_o, exp_tf);
        if (!exp_tf && !exp_to) begin
          check("min1_idx", min1_idx_o, exp_m1i);
          check("min2_idx", min2_idx_o, exp_m2i);
          check("min1_val", min1_val_o, exp_m1v);
          check("min2_val", min2_val_o, exp_m2v);
        end
      end
      prev_start <= cmp_start_o;
      prev_a <= cmp_a_o;
      prev_b <= cmp_b_o;
    end else prev_start <= 0;
  end

  // Reference: smallest active entry (lowest index on ties), then smallest of the rest
  task automatic model(input int n);
    int b1 = -1, b2 = -1, na = 0;
    for (int i = 0; i < n; i++)
      if (tb_act[i]) begin
        na++;
        if (b1 < 0 || tb_freq[i] < tb_freq[b1]) b1 = i;
      end
    for (int i = 0; i < n; i++)
      if (tb_act[i] && i != b1 && (b2 < 0 || tb_freq[i] < tb_freq[b2])) b2 = i;
    exp_tf = (na < 2);
    exp_to = 0;
    exp_m1i = (b1 < 0) ? 0 : b1;
    exp_m2i = (b2 < 0) ? 0 : b2;
    exp_m1v = (b1 < 0) ? 0 : tb_freq[b1];
    exp_m2v = (b2 < 0) ? 0 : tb_freq[b2];
  endtask

  task automatic clear_table();
    for (int i = 0; i < 16; i++) begin tb_freq[i] = 0; tb_act[i] = 0; end
  endtask

  task automatic setn(input int i, input int f, input bit a);
    tb_freq[i] = f; tb_act[i] = a;
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk); start_i = 1; node_count_i = (IDXW+1)'(n);
    @(negedge clk); start_i = 0;
  endtask

  // lat = busy cycles between start acceptance and the done cycle
  task automatic wait_done(input string nm, input int d0, output int lat);
    lat = 0;
    while (!done_o && lat < 3000) begin @(negedge clk); lat++; end
    if (!done_o) begin
      n_checks++; n_fail++;
      $display("FAIL %s_done_timeout: got no done expected done", nm);
    end
    @(negedge clk);
    check({nm, "_done_width"}, done_o, 0);
    check({nm, "_done_count"}, done_cnt, d0 + 1);
  endtask

  task automatic run_scan(input string nm, input int n, output int lat);
    int d0 = done_cnt;
    model(n);
    pulse_start(n);
    wait_done(nm, d0, lat);
    $display("%s: count=%0d lat=%0d min1=%0d(%0d) min2=%0d(%0d) too_few=%0d tmo=%0d", nm, n,
             lat, min1_idx_o, min1_val_o, min2_idx_o, min2_val_o, too_few_o, timeout_err_o);
  endtask

  task automatic load_t1();
    clear_table();
    setn(0, 5, 1); setn(1, 3, 1); setn(2, 7, 1); setn(3, 3, 1);
  endtask

  initial begin
    int lat, d0, k;
    // Reset state
    #12;
    check("rst_cmp_reset", cmp_reset_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd_en", rd_en_o, 0);
    check("rst_cmp_start", cmp_start_o, 0);
    check("rst_num_bits", cmp_num_bits_o, DW);
    check("rst_mins", {min1_idx_o, min2_idx_o, min1_val_o, min2_val_o}, 0);
    @(negedge clk); reset_ni = 1;

    // T1
    load_t1();
    run_scan("T1", 4, lat);
    check("T1_lat", lat, 36);
    check("T1_min1_idx_lit", min1_idx_o, 1);
    check("T1_min2_idx_lit", min2_idx_o, 3);
    check("T1_vals_lit", {min1_val_o, min2_val_o}, {9'd3, 9'd3});
    check("T1_hold_idle", min1_idx_o, 1);

    // T2: idx1 inactive
    clear_table();
    setn(0, 9, 1); setn(1, 2, 0); setn(2, 8, 1); setn(3, 1, 1); setn(4, 4, 1);
    run_scan("T2", 5, lat);
    check("T2_lat", lat, 45);
    check("T2_min1_lit", {min1_idx_o, min1_val_o}, {4'd3, 9'd1});
    check("T2_min2_lit", {min2_idx_o, min2_val_o}, {4'd4, 9'd4});

    // T3: one active node; then counts below two
    clear_table();
    setn(2, 6, 1);
    run_scan("T3a", 3, lat);
    check("T3a_too_few_lit", too_few_o, 1);
    check("T3a_lat", lat, 9);
    run_scan("T3b", 1, lat);
    check("T3b_lat_le1", lat <= 1, 1);
    run_scan("T3c", 0, lat);
    check("T3c_too_few_lit", too_few_o, 1);

    // Ties everywhere, fast comparator
    cmp_lat = 1;
    clear_table();
    for (int i = 0; i < 5; i++) setn(i, 42, 1);
    run_scan("TIES", 5, lat);
    check("TIES_idx_lit", {min1_idx_o, min2_idx_o}, {4'd0, 4'd1});

    // Full table, mixed activity, zero and max values
    clear_table();
    setn(0, 20, 1); setn(1, 15, 1); setn(2, 30, 1); setn(3, 15, 1);
    setn(4, 7, 0);  setn(5, 100, 1); setn(6, 7, 1); setn(7, 511, 1);
    setn(8, 0, 0);  setn(9, 3, 1);  setn(10, 0, 1); setn(11, 50, 1);
    setn(12, 2, 1); setn(13, 9, 0); setn(14, 1, 1); setn(15, 0, 1);
    run_scan("FULL", 16, lat);
    check("FULL_idx_lit", {min1_idx_o, min2_idx_o}, {4'd10, 4'd15});
    // Two-node boundary, second one larger
    clear_table();
    setn(0, 4, 1); setn(1, 6, 1);
    run_scan("TWO", 2, lat);
    cmp_lat = 3;

    // T4: comparator never finishes
    hang = 1;
    d0 = done_cnt;
    model(2);
    exp_to = 1;
    pulse_start(2);
    wait_done("T4", d0, lat);
    check("T4_timeout_lit", timeout_err_o, 1);
    check("T4_done_after_cmp", done_cyc - cmp_enter_cyc, TMO + 1);
    $display("T4: lat=%0d timeout_err=%0d cmp_to_done=%0d", lat, timeout_err_o, done_cyc - cmp_enter_cyc);
    hang = 0;

    // T5: reset in the middle of a comparison
    load_t1();
    model(4);
    d0 = done_cnt;
    pulse_start(4);
    k = 0;
    while (!cmp_start_o && k < 200) begin @(negedge clk); k++; end
    check("T5_reached_cmp", cmp_start_o, 1);
    #2 reset_ni = 0;
    #1;
    check("T5_busy", busy_o, 0);
    check("T5_cmp_reset", cmp_reset_o, 1);
    check("T5_cmp_start", cmp_start_o, 0);
    check("T5_outputs_zero", {done_o, rd_en_o, too_few_o, timeout_err_o, cmp_a_o, cmp_b_o,
                              min1_idx_o, min2_idx_o, min1_val_o, min2_val_o}, 0);
    repeat (3) @(negedge clk);
    check("T5_no_done", done_cnt, d0);
    reset_ni = 1;
    repeat (2) @(negedge clk);
    check("T5_no_done_after_release", done_cnt, d0);
    run_scan("T5", 4, lat);
    check("T5_min_lit", {min1_idx_o, min2_idx_o}, {4'd1, 4'd3});

    // T6: start while busy is ignored
    clear_table();
    setn(0, 8, 1); setn(1, 8, 1);
    run_scan("T6pre", 2, lat);
    load_t1();
    model(4);
    d0 = done_cnt;
    pulse_start(4);
    repeat (5) @(negedge clk);
    start_i = 1; node_count_i = 2;
    @(negedge clk); start_i = 0;
    wait_done("T6", d0, lat);
    check("T6_min_lit", {min1_idx_o, min2_idx_o, min1_val_o, min2_val_o},
          {4'd1, 4'd3, 9'd3, 9'd3});
    repeat (60) @(negedge clk);
    check("T6_single_done", done_cnt, d0 + 1);
    $display("T6: min1=%0d min2=%0d dones=%0d", min1_idx_o, min2_idx_o, done_cnt - d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench did not finish");
  end
endmodule
